// File: rtl/analogue_pkg.sv
// Shared definitions for the serial FIR MAC: FSM encoding and width helpers.
// Parameter-dependent widths are computed here so every file derives them the same way.
package analogue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_OUT  = 2'd3
    } fir_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Channel select is at least one bit wide, even for a single channel.
    function automatic int chan_width(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

    // Sum of N products of PRECISION x COEFF_WIDTH signed values cannot overflow this.
    function automatic int acc_width(input int precision, input int coeff_width, input int taps);
        return precision + coeff_width + clog2(taps);
    endfunction

endpackage

// File: rtl/fir_serial_mac_if.sv
// Sample, coefficient and result signals of the serial FIR MAC.
// The slave modport is the filter side; the master modport is the driver side.
interface fir_serial_mac_if
    import analogue_pkg::*;
#(
    parameter int N           = 8,
    parameter int CHANNELS    = 2,
    parameter int PRECISION   = 16,
    parameter int COEFF_WIDTH = 8
);
    localparam int CW = chan_width(CHANNELS);
    localparam int AW = clog2(N);

    logic                          in_valid;
    logic                          in_ready;
    logic [CW-1:0]                 in_channel;
    logic signed [PRECISION-1:0]   x;
    logic                          coef_we;
    logic [AW-1:0]                 coef_addr;
    logic signed [COEFF_WIDTH-1:0] coef_data;
    logic                          coef_err;
    logic                          out_valid;
    logic [CW-1:0]                 out_channel;
    logic signed [PRECISION-1:0]   y;
    logic                          overflow;

    modport slave (
        input  in_valid, in_channel, x, coef_we, coef_addr, coef_data,
        output in_ready, coef_err, out_valid, out_channel, y, overflow
    );

    modport master (
        output in_valid, in_channel, x, coef_we, coef_addr, coef_data,
        input  in_ready, coef_err, out_valid, out_channel, y, overflow
    );

endinterface

// File: rtl/fir_round_sat.sv
// Round-half-up by 2^(Q-1), arithmetic shift right by Q, then clamp to the signed
// PRECISION range. One guard bit keeps the rounding add from wrapping.
module fir_round_sat #(
    parameter int ACC_W     = 26,
    parameter int PRECISION = 16,
    parameter int Q         = 6
) (
    input  logic signed [ACC_W-1:0]     acc_i,
    output logic signed [PRECISION-1:0] y_o,
    output logic                        ovf_o
);
    localparam int W = ACC_W + 1;
    localparam logic signed [W-1:0] MAX_V = {{(W-PRECISION+1){1'b0}}, {(PRECISION-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {{(W-PRECISION+1){1'b1}}, {(PRECISION-1){1'b0}}};

    logic signed [W-1:0] acc_ext;
    logic signed [W-1:0] rounded;

    assign acc_ext = {acc_i[ACC_W-1], acc_i};

    generate
        if (Q > 0) begin : g_round
            localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
            localparam logic signed [W-1:0] HALF = ONE << (Q - 1);
            assign rounded = (acc_ext + HALF) >>> Q;
        end else begin : g_pass
            assign rounded = acc_ext;
        end
    endgenerate

    always_comb begin
        y_o   = rounded[PRECISION-1:0];
        ovf_o = 1'b0;
        if (rounded > MAX_V) begin
            y_o   = MAX_V[PRECISION-1:0];
            ovf_o = 1'b1;
        end else if (rounded < MIN_V) begin
            y_o   = MIN_V[PRECISION-1:0];
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed N-tap FIR: one shared multiplier walks the taps of the selected
// channel's delay line, one coefficient set is shared by all channels.
//
//   state   | meaning
//   IDLE    | ready for a sample; coefficient writes allowed
//   LOAD    | shift the channel's delay line, insert sample, clear accumulator
//   MAC     | one tap per cycle, k = 0..N-1
//   OUT     | result strobe; y/out_channel/overflow held until the next OUT
module fir_serial_mac
    import analogue_pkg::*;
#(
    parameter int N           = 8,
    parameter int CHANNELS    = 2,
    parameter int PRECISION   = 16,
    parameter int COEFF_WIDTH = 8,
    parameter int Q           = 6
) (
    input logic               clk,
    input logic               rst,
    fir_serial_mac_if.slave   bus
);
    localparam int CW     = chan_width(CHANNELS);
    localparam int TW     = clog2(N);
    localparam int ACC_W  = acc_width(PRECISION, COEFF_WIDTH, N);
    localparam int PROD_W = PRECISION + COEFF_WIDTH;

    localparam logic [CW:0]   CH_LIMIT  = (CW+1)'(CHANNELS);
    localparam logic [TW:0]   TAP_LIMIT = (TW+1)'(N);
    localparam logic [TW-1:0] TAP_LAST  = TW'(N - 1);

    fir_state_e                    state_q, state_d;
    logic [TW-1:0]                 tap_q, tap_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [CW-1:0]                 ch_q;
    logic signed [PRECISION-1:0]   x_q;
    logic signed [COEFF_WIDTH-1:0] coef_q  [N];
    logic signed [PRECISION-1:0]   dline_q [CHANNELS][N];
    logic signed [PRECISION-1:0]   y_q;
    logic [CW-1:0]                 out_ch_q;
    logic                          ovf_q;
    logic                          coef_err_q;

    logic                          accept;
    logic                          ch_valid;
    logic                          coef_wr;
    logic                          mac_last;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       prod_ext;
    logic signed [PRECISION-1:0]   rs_y;
    logic                          rs_ovf;

    assign accept   = bus.in_valid && (state_q == ST_IDLE);
    assign ch_valid = ({1'b0, bus.in_channel} < CH_LIMIT);
    assign coef_wr  = bus.coef_we && (state_q == ST_IDLE) && ({1'b0, bus.coef_addr} < TAP_LIMIT);

    assign prod     = coef_q[tap_q] * dline_q[ch_q][tap_q];
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Rounding sees the accumulator value including the final tap, so the result
    // register is loaded on the last MAC edge and is already valid during OUT.
    fir_round_sat #(
        .ACC_W     (ACC_W),
        .PRECISION (PRECISION),
        .Q         (Q)
    ) u_round_sat (
        .acc_i (acc_d),
        .y_o   (rs_y),
        .ovf_o (rs_ovf)
    );

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        acc_d    = acc_q;
        mac_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && ch_valid) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_MAC;
                tap_d   = '0;
                acc_d   = '0;
            end
            ST_MAC: begin
                acc_d = acc_q + prod_ext;
                if (tap_q == TAP_LAST) begin
                    state_d  = ST_OUT;
                    mac_last = 1'b1;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tap_q      <= '0;
            acc_q      <= '0;
            ch_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            out_ch_q   <= '0;
            ovf_q      <= 1'b0;
            coef_err_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                coef_q[k] <= '0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < N; k++) begin
                    dline_q[c][k] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            coef_err_q <= bus.coef_we && (state_q != ST_IDLE);
            if (accept) begin
                ch_q <= bus.in_channel;
                x_q  <= bus.x;
            end
            if (coef_wr) begin
                coef_q[bus.coef_addr] <= bus.coef_data;
            end
            if (state_q == ST_LOAD) begin
                for (int k = N - 1; k > 0; k--) begin
                    dline_q[ch_q][k] <= dline_q[ch_q][k-1];
                end
                dline_q[ch_q][0] <= x_q;
            end
            if (mac_last) begin
                y_q      <= rs_y;
                ovf_q    <= rs_ovf;
                out_ch_q <= ch_q;
            end
        end
    end

    assign bus.in_ready    = (state_q == ST_IDLE);
    // A reset arriving in the OUT cycle suppresses the strobe as well.
    assign bus.out_valid   = (state_q == ST_OUT) && !rst;
    assign bus.y           = y_q;
    assign bus.out_channel = out_ch_q;
    assign bus.overflow    = ovf_q;
    assign bus.coef_err    = coef_err_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: directed scenarios plus randomized traffic, checked
// against an arithmetic model of per-channel history and shared coefficients.
module tb_fir_serial_mac;
    localparam int N   = 4;
    localparam int CH  = 2;
    localparam int PW  = 16;
    localparam int CWD = 8;
    localparam int Q   = 6;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fir_serial_mac_if #(.N(N), .CHANNELS(CH), .PRECISION(PW), .COEFF_WIDTH(CWD)) bus ();
    fir_serial_mac_if #(.N(N), .CHANNELS(3),  .PRECISION(PW), .COEFF_WIDTH(CWD)) bus3 ();

    fir_serial_mac #(.N(N), .CHANNELS(CH), .PRECISION(PW), .COEFF_WIDTH(CWD), .Q(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fir_serial_mac #(.N(N), .CHANNELS(3), .PRECISION(PW), .COEFF_WIDTH(CWD), .Q(Q)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int vectors     = 0;
    int miscompares = 0;
    int mb  [N];
    int mdl [CH][N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            mb[k] = 0;
            for (int c = 0; c < CH; c++) mdl[c][k] = 0;
        end
    endfunction

    // y = sat(round(sum b[k]*x[n-k]) >> Q), computed in 64-bit arithmetic
    function automatic void model_step(input int ch, input int xv, output int ey, output bit eo);
        longint acc;
        for (int k = N - 1; k > 0; k--) mdl[ch][k] = mdl[ch][k-1];
        mdl[ch][0] = xv;
        acc = 0;
        for (int k = 0; k < N; k++) acc += longint'(mb[k]) * longint'(mdl[ch][k]);
        acc = (acc + (longint'(1) <<< (Q - 1))) >>> Q;
        eo = 1'b0;
        if (acc > 32767) begin
            acc = 32767;
            eo  = 1'b1;
        end else if (acc < -32768) begin
            acc = -32768;
            eo  = 1'b1;
        end
        ey = int'(acc);
    endfunction

    task automatic wait_ready();
        int g;
        g = 0;
        while (bus.in_ready !== 1'b1 && g < 50) begin
            tick();
            g++;
        end
        if (g >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, g);
        end
    endtask

    task automatic write_coef(input int a, input int d);
        logic [CWD-1:0] dbits;
        logic [1:0]     abits;
        wait_ready();
        dbits = d[CWD-1:0];
        abits = a[1:0];
        bus.coef_we   = 1'b1;
        bus.coef_addr = abits;
        bus.coef_data = dbits;
        tick();
        bus.coef_we = 1'b0;
        mb[a] = d;
        vectors++;
        if (bus.coef_err !== 1'b0) begin
            miscompares++;
            $display("FAIL coef_err_idle: coef_err=%b, required 0", bus.coef_err);
        end
    endtask

    task automatic send_sample(input int ch, input int xv, input bit cw, input int ca, input int cd);
        int ey;
        bit eo;
        int lat;
        logic signed [PW-1:0] ey_v;
        logic [PW-1:0]  xbits;
        logic [CWD-1:0] dbits;
        logic [1:0]     abits;
        logic [0:0]     cbits;
        wait_ready();
        xbits = xv[PW-1:0];
        cbits = ch[0:0];
        bus.in_valid   = 1'b1;
        bus.in_channel = cbits;
        bus.x          = xbits;
        if (cw) begin
            dbits = cd[CWD-1:0];
            abits = ca[1:0];
            bus.coef_we   = 1'b1;
            bus.coef_addr = abits;
            bus.coef_data = dbits;
            mb[ca] = cd;
        end
        model_step(ch, xv, ey, eo);
        ey_v = ey[PW-1:0];
        tick();
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat != N + 2) begin
            miscompares++;
            $display("FAIL latency ch%0d x=%0d: got %0d cycles, required %0d", ch, xv, lat, N + 2);
        end
        vectors++;
        if (bus.y !== ey_v) begin
            miscompares++;
            $display("FAIL y ch%0d x=%0d: got %0d, required %0d", ch, xv, bus.y, ey_v);
        end
        vectors++;
        if (bus.out_channel !== cbits) begin
            miscompares++;
            $display("FAIL out_channel: got %0d, required %0d", bus.out_channel, cbits);
        end
        vectors++;
        if (bus.overflow !== eo) begin
            miscompares++;
            $display("FAIL overflow ch%0d x=%0d: got %b, required %b", ch, xv, bus.overflow, eo);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.y !== ey_v) begin
            miscompares++;
            $display("FAIL after_out: out_valid=%b in_ready=%b y=%0d, required 0 1 %0d",
                     bus.out_valid, bus.in_ready, bus.y, ey_v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.coef_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b coef_err=%b, required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.coef_err);
        end
        vectors++;
        if (bus.y !== '0 || bus.out_channel !== '0 || bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data: y=%0d out_channel=%0d overflow=%b, required 0 0 0",
                     bus.y, bus.out_channel, bus.overflow);
        end
    endtask

    task automatic test_discard();
        int  lat;
        bit  seen;
        bit  rdy_ok;
        bus3.coef_we   = 1'b1;
        bus3.coef_addr = 2'd0;
        bus3.coef_data = 8'sd64;
        tick();
        bus3.coef_we    = 1'b0;
        bus3.in_valid   = 1'b1;
        bus3.in_channel = 2'd3;
        bus3.x          = 16'sd500;
        tick();
        bus3.in_valid = 1'b0;
        seen   = 1'b0;
        rdy_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus3.out_valid === 1'b1) seen = 1'b1;
            if (bus3.in_ready !== 1'b1) rdy_ok = 1'b0;
            tick();
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL discard_out_valid: out_valid seen=1, required 0");
        end
        vectors++;
        if (!rdy_ok) begin
            miscompares++;
            $display("FAIL discard_in_ready: in_ready dropped=1, required 0");
        end
        bus3.in_valid   = 1'b1;
        bus3.in_channel = 2'd2;
        bus3.x          = 16'sd700;
        tick();
        bus3.in_valid = 1'b0;
        lat = 1;
        while (bus3.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat != N + 2 || bus3.y !== 16'sd700 || bus3.out_channel !== 2'd2) begin
            miscompares++;
            $display("FAIL ch2_after_discard: lat=%0d y=%0d ch=%0d, required %0d 700 2",
                     lat, bus3.y, bus3.out_channel, N + 2);
        end
    endtask

    task automatic test_impulse();
        write_coef(0, 64);
        write_coef(1, 32);
        write_coef(2, 16);
        write_coef(3, 8);
        send_sample(0, 1000, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) send_sample(0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_isolation();
        send_sample(0, 1000, 1'b0, 0, 0);
        send_sample(1, -2000, 1'b0, 0, 0);
        send_sample(0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < N; k++) write_coef(k, 127);
        for (int i = 0; i < 4; i++) send_sample(0, 32767, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) send_sample(0, -32768, 1'b0, 0, 0);
    endtask

    task automatic test_rounding();
        write_coef(0, 1);
        for (int k = 1; k < N; k++) write_coef(k, 0);
        send_sample(0, 32, 1'b0, 0, 0);
        send_sample(0, -32, 1'b0, 0, 0);
        send_sample(0, 31, 1'b0, 0, 0);
    endtask

    task automatic test_coef_during_mac();
        int ey;
        bit eo;
        int lat;
        logic signed [PW-1:0] ey_v;
        write_coef(0, 64);
        write_coef(1, 32);
        wait_ready();
        bus.in_valid   = 1'b1;
        bus.in_channel = 1'b0;
        bus.x          = 16'sd1000;
        model_step(0, 1000, ey, eo);
        ey_v = ey[PW-1:0];
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'd0;
        bus.coef_data = 8'sd99;
        tick();
        bus.coef_we = 1'b0;
        vectors++;
        if (bus.coef_err !== 1'b1) begin
            miscompares++;
            $display("FAIL coef_err_pulse: coef_err=%b, required 1", bus.coef_err);
        end
        tick();
        vectors++;
        if (bus.coef_err !== 1'b0) begin
            miscompares++;
            $display("FAIL coef_err_single: coef_err=%b, required 0", bus.coef_err);
        end
        lat = 4;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat != N + 2 || bus.y !== ey_v) begin
            miscompares++;
            $display("FAIL mac_with_we: lat=%0d y=%0d, required %0d %0d", lat, bus.y, N + 2, ey_v);
        end
        tick();
        send_sample(0, 1234, 1'b0, 0, 0);
        send_sample(1, -777, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_mac();
        bit seen;
        wait_ready();
        bus.in_valid   = 1'b1;
        bus.in_channel = 1'b1;
        bus.x          = 16'sd5000;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        vectors++;
        if (seen || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_abort: out_valid seen=%b in_ready=%b, required 0 1", seen, bus.in_ready);
        end
        send_sample(0, 1000, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0]  r16;
        logic [CWD-1:0] r8;
        int ch;
        int xv;
        int cd;
        for (int k = 0; k < N; k++) begin
            r8 = CWD'($urandom);
            write_coef(k, int'($signed(r8)));
        end
        for (int i = 0; i < 24; i++) begin
            r16 = PW'($urandom);
            r8  = CWD'($urandom);
            ch  = int'($urandom_range(0, CH - 1));
            xv  = int'($signed(r16));
            cd  = int'($signed(r8));
            if (i % 8 == 3) xv = 32767;
            if (i % 8 == 7) xv = -32768;
            send_sample(ch, xv, ($urandom_range(0, 3) == 0), int'($urandom_range(0, N - 1)), cd);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_channel  = '0;
        bus.x           = '0;
        bus.coef_we     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_data   = '0;
        bus3.in_valid   = 1'b0;
        bus3.in_channel = '0;
        bus3.x          = '0;
        bus3.coef_we    = 1'b0;
        bus3.coef_addr  = '0;
        bus3.coef_data  = '0;

        test_reset();
        test_discard();
        test_impulse();
        test_isolation();
        test_saturation();
        test_rounding();
        test_coef_during_mac();
        test_reset_mid_mac();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
